// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX branch resolution plus the EX/MEM pipeline register with stall, flush and valid.
// Define PERF_CNT_EN to build the branch_cnt/taken_cnt performance counters; otherwise they read 0.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_m,
    input  logic             flush_m,
    input  logic             valid_e,
    input  logic [XLEN-1:0]  alu_result_e,
    input  logic             flag_v_e,
    input  logic             flag_c_e,
    input  logic             flag_n_e,
    input  logic             flag_z_e,
    input  logic [XLEN-1:0]  write_data_e,
    input  logic [4:0]       rd_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             branch_e,
    input  logic             jump_e,
    input  logic [1:0]       result_src_e,
    input  logic [2:0]       funct3_e,
    input  logic [XLEN-1:0]  pc_plus4_e,
    output logic             pc_src_e,
    output logic             valid_m,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [1:0]       result_src_m,
    output logic [4:0]       rd_m,
    output logic [XLEN-1:0]  alu_result_m,
    output logic [XLEN-1:0]  write_data_m,
    output logic [XLEN-1:0]  pc_plus4_m,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    logic cond;
    logic lt;
    always_comb begin
        lt   = flag_n_e ^ flag_v_e;
        cond = (funct3_e == 3'b000) ? flag_z_e :
               (funct3_e == 3'b001) ? !flag_z_e :
               (funct3_e == 3'b100) ? lt :
               (funct3_e == 3'b101) ? !lt :
               (funct3_e == 3'b110) ? flag_c_e :
               (funct3_e == 3'b111) ? !flag_c_e : 1'b0;
    end
    // Not gated by stall/flush: the hazard unit decides whether a redirect is squashed.
    assign pc_src_e = valid_e & (jump_e | (branch_e & cond));
    always_ff @(posedge clk) begin
        if (reset || flush_m) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= '0;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else if (!stall_m) begin
            valid_m      <= valid_e;
            reg_write_m  <= reg_write_e & valid_e;
            mem_write_m  <= mem_write_e & valid_e;
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            alu_result_m <= alu_result_e;
            write_data_m <= write_data_e;
            pc_plus4_m   <= pc_plus4_e;
        end
    end
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] tk_q;
    logic             count_en;
    assign count_en = valid_e & (branch_e | jump_e) & !stall_m & !flush_m;
    always_ff @(posedge clk) begin
        if (reset) begin
            br_q <= '0;
            tk_q <= '0;
        end else if (count_en) begin
            br_q <= br_q + CNT_W'(1);
            tk_q <= pc_src_e ? tk_q + CNT_W'(1) : tk_q;
        end
    end
    assign branch_cnt = br_q;
    assign taken_cnt  = tk_q;
`else
    assign branch_cnt = '0;
    assign taken_cnt  = '0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized and directed checks of ex_mem_stage against an operand-level reference model.
module tb_ex_mem_stage;
    localparam int XLEN = 32;
    localparam int CW   = 4;
`ifdef PERF_CNT_EN
    localparam logic [CW-1:0] WRAP_EXP = 4'd1;
`else
    localparam logic [CW-1:0] WRAP_EXP = 4'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, stall_m, flush_m, valid_e;
    logic [XLEN-1:0] alu_result_e, write_data_e, pc_plus4_e;
    logic            flag_v_e, flag_c_e, flag_n_e, flag_z_e;
    logic [4:0]      rd_e;
    logic            reg_write_e, mem_write_e, branch_e, jump_e;
    logic [1:0]      result_src_e;
    logic [2:0]      funct3_e;
    logic            pc_src_e, valid_m, reg_write_m, mem_write_m;
    logic [1:0]      result_src_m;
    logic [4:0]      rd_m;
    logic [XLEN-1:0] alu_result_m, write_data_m, pc_plus4_m;
    logic [CW-1:0]   branch_cnt, taken_cnt;

    ex_mem_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall_m(stall_m), .flush_m(flush_m), .valid_e(valid_e),
        .alu_result_e(alu_result_e), .flag_v_e(flag_v_e), .flag_c_e(flag_c_e),
        .flag_n_e(flag_n_e), .flag_z_e(flag_z_e), .write_data_e(write_data_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .result_src_e(result_src_e), .funct3_e(funct3_e),
        .pc_plus4_e(pc_plus4_e), .pc_src_e(pc_src_e), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .rd_m(rd_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    logic            m_valid, m_rw, m_mw, exp_pc;
    logic [1:0]      m_rs;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_alu, m_wd, m_pc;
    logic [CW-1:0]   m_br, m_tk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_m"}, 64'(valid_m), 64'(m_valid));
        chk({tag, ".reg_write_m"}, 64'(reg_write_m), 64'(m_rw));
        chk({tag, ".mem_write_m"}, 64'(mem_write_m), 64'(m_mw));
        chk({tag, ".result_src_m"}, 64'(result_src_m), 64'(m_rs));
        chk({tag, ".rd_m"}, 64'(rd_m), 64'(m_rd));
        chk({tag, ".alu_result_m"}, 64'(alu_result_m), 64'(m_alu));
        chk({tag, ".write_data_m"}, 64'(write_data_m), 64'(m_wd));
        chk({tag, ".pc_plus4_m"}, 64'(pc_plus4_m), 64'(m_pc));
`ifdef PERF_CNT_EN
        chk({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(m_br));
        chk({tag, ".taken_cnt"}, 64'(taken_cnt), 64'(m_tk));
`else
        chk({tag, ".branch_cnt"}, 64'(branch_cnt), 64'd0);
        chk({tag, ".taken_cnt"}, 64'(taken_cnt), 64'd0);
`endif
    endtask

    task automatic clear_model_fields();
        m_valid = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_rs = '0; m_rd = '0;
        m_alu = '0; m_wd = '0; m_pc = '0;
    endtask

    task automatic tick(input string tag);
        if (reset) begin
            clear_model_fields();
            m_br = '0;
            m_tk = '0;
        end else if (flush_m) begin
            clear_model_fields();
        end else if (!stall_m) begin
            m_valid = valid_e;
            m_rw = reg_write_e && valid_e;
            m_mw = mem_write_e && valid_e;
            m_rs = result_src_e; m_rd = rd_e;
            m_alu = alu_result_e; m_wd = write_data_e; m_pc = pc_plus4_e;
            if (valid_e && (branch_e || jump_e)) begin
                m_br = m_br + 1'b1;
                if (exp_pc) m_tk = m_tk + 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive_nop();
        valid_e = 1'b0; alu_result_e = '0; write_data_e = '0; pc_plus4_e = '0;
        flag_v_e = 1'b0; flag_c_e = 1'b0; flag_n_e = 1'b0; flag_z_e = 1'b0;
        rd_e = '0; reg_write_e = 1'b0; mem_write_e = 1'b0; branch_e = 1'b0; jump_e = 1'b0;
        result_src_e = '0; funct3_e = '0; exp_pc = 1'b0;
    endtask

    // Flags come from a real subtraction a-b; the expected outcome from a direct comparison of a and b.
    task automatic drive_rand(input bit force_valid);
        logic [31:0] a, b, d;
        logic c;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        d = a - b;
        flag_z_e = (d == 0);
        flag_n_e = d[31];
        flag_c_e = (a < b);
        flag_v_e = (a[31] != b[31]) && (d[31] != a[31]);
        funct3_e = 3'($urandom_range(0, 7));
        case (funct3_e)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = ($signed(a) >= $signed(b));
            3'd6: c = (a < b);
            3'd7: c = (a >= b);
            default: c = 1'b0;
        endcase
        valid_e = force_valid || ($urandom_range(0, 3) != 0);
        branch_e = 1'($urandom_range(0, 1));
        jump_e = ($urandom_range(0, 3) == 0);
        reg_write_e = 1'($urandom_range(0, 1));
        mem_write_e = 1'($urandom_range(0, 1));
        result_src_e = 2'($urandom_range(0, 3));
        rd_e = 5'($urandom_range(0, 31));
        alu_result_e = $urandom; write_data_e = $urandom; pc_plus4_e = $urandom;
        exp_pc = valid_e && (jump_e || (branch_e && c));
        #1;
        chk("pc_src_rand", 64'(pc_src_e), 64'(exp_pc));
    endtask

    task automatic set_br(input string tag, input logic [2:0] f3, input logic v, input logic c,
                          input logic n, input logic z, input logic e);
        valid_e = 1'b1; branch_e = 1'b1; jump_e = 1'b0; funct3_e = f3;
        flag_v_e = v; flag_c_e = c; flag_n_e = n; flag_z_e = z; exp_pc = e;
        #1;
        chk(tag, 64'(pc_src_e), 64'(e));
    endtask

    initial begin
        m_br = '0; m_tk = '0;
        clear_model_fields();
        drive_nop();
        reset = 1'b1; stall_m = 1'b0; flush_m = 1'b0;
        tick("reset0");
        tick("reset1");
        reset = 1'b0;

        alu_result_e = 32'h0000_1234; rd_e = 5'd5; reg_write_e = 1'b1; valid_e = 1'b1;
        tick("load");
        chk("load.alu_const", 64'(alu_result_m), 64'h1234);
        chk("load.rd_const", 64'(rd_m), 64'd5);

        set_br("bltu_c1", 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        set_br("bge_nv11", 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        set_br("blt_n1v0", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        set_br("f3_010", 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_br("f3_011", 3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_br("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("br_load");

        drive_rand(1'b1);
        tick("pre_stall");
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b0);
            tick("stall");
        end
        flush_m = 1'b1;
        tick("flush_stall");
        chk("flush_stall.valid_const", 64'(valid_m), 64'd0);
        flush_m = 1'b0; stall_m = 1'b0;

        drive_nop();
        valid_e = 1'b0; mem_write_e = 1'b1; jump_e = 1'b1; exp_pc = 1'b0;
        #1;
        chk("invalid_jump_pc_src", 64'(pc_src_e), 64'd0);
        tick("invalid_slot");
        chk("invalid_slot.mw_const", 64'(mem_write_m), 64'd0);

        reset = 1'b1;
        tick("cnt_reset");
        reset = 1'b0;
        drive_nop();
        valid_e = 1'b1; jump_e = 1'b1; exp_pc = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 8) begin
                stall_m = 1'b1;
                tick("jump_stall");
                tick("jump_stall");
                stall_m = 1'b0;
            end
            tick("jump");
        end
        chk("wrap.branch_cnt", 64'(branch_cnt), 64'(WRAP_EXP));
        chk("wrap.taken_cnt", 64'(taken_cnt), 64'(WRAP_EXP));
        jump_e = 1'b0; branch_e = 1'b1; funct3_e = 3'b000; flag_z_e = 1'b1;
        flush_m = 1'b1;
        tick("flush_branch");
        flush_m = 1'b0;
        chk("flush_branch.branch_cnt", 64'(branch_cnt), 64'(WRAP_EXP));

        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall_m = ($urandom_range(0, 4) == 0);
            flush_m = ($urandom_range(0, 9) == 0);
            drive_rand(1'b0);
            tick("rand");
        end
        reset = 1'b0; stall_m = 1'b0; flush_m = 1'b0;

        drive_rand(1'b1);
        tick("pre_rst_stall");
        stall_m = 1'b1;
        drive_rand(1'b1);
        tick("rst_stall_hold");
        reset = 1'b1;
        tick("rst_mid_stall");
        chk("rst_mid_stall.alu_zero", 64'(alu_result_m), 64'd0);
        chk("rst_mid_stall.branch_cnt_zero", 64'(branch_cnt), 64'd0);
        reset = 1'b0; stall_m = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
